intersection_arbiter: RTL and testbench

- Upstream controller for a bank of per-lane traffic-light FSMs. Decides which lane gets the next green and issues a one-cycle grant pulse to that lane's FSM.
- Enforces mutual exclusion: no grant until every lane reports red and an all-red clearance interval has elapsed.
- Selection is density-weighted with round-robin tie-break and a starvation guard.
- Sits between sensor front-end (lane_req, density) and the lane FSM array (grant out, red status back).

---
 rtl/intersection_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_intersection_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_arbiter.sv
// Grant arbiter for a bank of per-lane traffic-light FSMs: all-red clearance, density-weighted pick
// with round-robin ties and a starvation guard. Optional macro EMERGENCY_PREEMPT_EN adds emergency preemption.
module intersection_arbiter #(
    parameter int NUM_LANES   = 4,
    parameter int IDX_W       = 2,
    parameter int CLEAR_TIME  = 10,
    parameter int TIMER_WIDTH = 16,
    parameter int MAX_SKIP    = 3,
    parameter int SKIP_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_LANES-1:0]   lane_req,
    input  logic [2*NUM_LANES-1:0] density,
    input  logic [NUM_LANES-1:0]   lane_red,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                   emerg_valid,
    input  logic [IDX_W-1:0]       emerg_lane,
`endif
    output logic [NUM_LANES-1:0]   grant,
    output logic [IDX_W-1:0]       active_lane,
    output logic [NUM_LANES-1:0]   pending,
    output logic                   fault
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_ALLRED  = 3'd1,
        S_SELECT  = 3'd2,
        S_GRANT   = 3'd3,
        S_WAIT_GO = 3'd4
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic [TIMER_WIDTH-1:0] timer_r;
    logic [IDX_W-1:0]       winner_r;
    logic [IDX_W-1:0]       rr_ptr_r;
    logic [IDX_W-1:0]       active_lane_r;
    logic [NUM_LANES-1:0]   grant_r;
    logic [NUM_LANES-1:0]   pending_r;
    logic                   fault_r;
    logic [SKIP_W-1:0]      skip_r [NUM_LANES];

    logic                   fault_set_s;
    logic                   grant_load_s;
    logic                   sel_valid_s;
    logic                   emerg_clear_s;
    logic [IDX_W-1:0]       sel_winner_s;
    logic [IDX_W-1:0]       base_winner_s;
    logic [IDX_W-1:0]       scan_s;
    logic                   starve_hit_s;
    logic [IDX_W-1:0]       starve_idx_s;
    logic                   dens_hit_s;
    logic [IDX_W-1:0]       dens_idx_s;
    logic [1:0]             dens_best_s;

    function automatic logic [IDX_W-1:0] lane_at(input logic [IDX_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        lane_at = (sum >= NUM_LANES) ? IDX_W'(sum - NUM_LANES) : IDX_W'(sum);
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [IDX_W-1:0] idx);
        lane_onehot      = '0;
        lane_onehot[idx] = 1'b1;
    endfunction

    function automatic logic [1:0] dens_of(input logic [2*NUM_LANES-1:0] dens, input logic [IDX_W-1:0] idx);
        dens_of = dens[2*int'(idx) +: 2];
    endfunction

    assign grant       = grant_r;
    assign active_lane = active_lane_r;
    assign pending     = pending_r;
    assign fault       = fault_r;

    // Scan pending lanes from rr_ptr: first starving lane, else first lane of highest density
    always_comb begin
        starve_hit_s = 1'b0;
        starve_idx_s = '0;
        dens_hit_s   = 1'b0;
        dens_idx_s   = '0;
        dens_best_s  = 2'b00;
        scan_s       = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            scan_s = lane_at(rr_ptr_r, k);
            if (pending_r[scan_s] && !starve_hit_s && (skip_r[scan_s] == SKIP_W'(MAX_SKIP))) begin
                starve_hit_s = 1'b1;
                starve_idx_s = scan_s;
            end else begin
                starve_hit_s = starve_hit_s;
            end
            if (pending_r[scan_s] && (!dens_hit_s || (dens_of(density, scan_s) > dens_best_s))) begin
                dens_hit_s  = 1'b1;
                dens_idx_s  = scan_s;
                dens_best_s = dens_of(density, scan_s);
            end else begin
                dens_hit_s = dens_hit_s;
            end
        end
        base_winner_s = starve_hit_s ? starve_idx_s : dens_idx_s;
    end

`ifdef EMERGENCY_PREEMPT_EN
    assign sel_valid_s   = emerg_valid | (|pending_r);
    assign sel_winner_s  = emerg_valid ? emerg_lane : base_winner_s;
    assign emerg_clear_s = emerg_valid;
`else
    assign sel_valid_s   = |pending_r;
    assign sel_winner_s  = base_winner_s;
    assign emerg_clear_s = 1'b0;
`endif

    // Next-state logic and conflict detection
    always_comb begin
        state_nxt_s  = state_r;
        fault_set_s  = 1'b0;
        grant_load_s = 1'b0;
        case (state_r)
            S_CLEAR: begin
                if (&lane_red) state_nxt_s = S_ALLRED;
                else           state_nxt_s = S_CLEAR;
            end
            S_ALLRED: begin
                if (!(&lane_red)) begin
                    fault_set_s = 1'b1;
                    state_nxt_s = S_CLEAR;
                end else if (timer_r == '0) begin
                    state_nxt_s = S_SELECT;
                end else begin
                    state_nxt_s = S_ALLRED;
                end
            end
            S_SELECT: begin
                if (!(&lane_red)) begin
                    fault_set_s = 1'b1;
                    state_nxt_s = S_CLEAR;
                end else if (sel_valid_s) begin
                    grant_load_s = 1'b1;
                    state_nxt_s  = S_GRANT;
                end else begin
                    state_nxt_s = S_SELECT;
                end
            end
            S_GRANT: state_nxt_s = S_WAIT_GO;
            S_WAIT_GO: begin
                fault_set_s = |(~lane_red & ~lane_onehot(winner_r));
                if (!lane_red[winner_r]) state_nxt_s = S_CLEAR;
                else                     state_nxt_s = S_WAIT_GO;
            end
            default: state_nxt_s = S_CLEAR;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= S_CLEAR;
        else          state_r <= state_nxt_s;
    end

    // Clearance timer, grant pulse, round-robin pointer, skip counters, pending latch and sticky fault
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_r       <= '0;
            winner_r      <= '0;
            rr_ptr_r      <= '0;
            active_lane_r <= '0;
            grant_r       <= '0;
            pending_r     <= '0;
            fault_r       <= 1'b0;
            for (int i = 0; i < NUM_LANES; i++) skip_r[i] <= '0;
        end else begin
            pending_r <= (pending_r | lane_req) & ~grant_r;
            fault_r   <= fault_r | fault_set_s;
            grant_r   <= grant_load_s ? lane_onehot(sel_winner_s) : '0;
            if (grant_load_s) winner_r <= sel_winner_s;
            case (state_r)
                S_CLEAR:  timer_r <= TIMER_WIDTH'(CLEAR_TIME);
                S_ALLRED: begin
                    if (emerg_clear_s)        timer_r <= '0;
                    else if (timer_r != '0)   timer_r <= timer_r - TIMER_WIDTH'(1);
                end
                S_GRANT: begin
                    active_lane_r <= winner_r;
                    rr_ptr_r      <= lane_at(winner_r, 1);
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (IDX_W'(i) == winner_r)
                            skip_r[i] <= '0;
                        else if (pending_r[i] && (skip_r[i] < SKIP_W'(MAX_SKIP)))
                            skip_r[i] <= skip_r[i] + SKIP_W'(1);
                    end
                end
                default: timer_r <= timer_r;
            endcase
        end
    end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter (default parameters, emergency macro undefined).
module tb_intersection_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] lane_req;
    logic [7:0] density;
    logic [3:0] lane_red;
    logic [3:0] grant;
    logic [1:0] active_lane;
    logic [3:0] pending;
    logic       fault;

    int errors = 0;
    int checks = 0;

    logic [3:0] g, g_next;
    int         n;
    int         seen;

    intersection_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lane_req    (lane_req),
        .density     (density),
        .lane_red    (lane_red),
        .grant       (grant),
        .active_lane (active_lane),
        .pending     (pending),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_grant(input int limit, output logic [3:0] gw, output int nw);
        gw = 4'b0000;
        nw = 0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (grant != 4'b0000) begin
                gw = grant;
                nw = i;
                break;
            end
        end
    endtask

    // Wait for a grant, then let the granted lane go green for one cycle and return to all-red
    task automatic serve(output logic [3:0] gs, output int ns, output logic [3:0] gn);
        wait_grant(40, gs, ns);
        gn = 4'b0000;
        if (gs != 4'b0000) begin
            step();
            gn       = grant;
            lane_red = ~gs;
            step();
            lane_red = 4'b1111;
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        lane_req = 4'b0000;
        density  = 8'h00;
        lane_red = 4'b1111;

        // Reset state
        step(); step(); step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_active", 32'(active_lane), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        reset_n = 1'b1;

        // Reset asserted mid-clearance
        lane_req = 4'b0001;
        step();
        lane_req = 4'b0000;
        step(); step();
        check("mid_pending_set", 32'(pending), 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_pending", 32'(pending), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h0);
        check("mid_rst_fault", 32'(fault), 32'h0);
        step();
        reset_n = 1'b1;

        // Idle: no requests, no grants
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (grant != 4'b0000) seen++;
        end
        check("idle_no_grant", 32'(seen), 32'h0);
        check("idle_pending", 32'(pending), 32'h0);

        // Basic grant: 13 cycles after all-red with lane 2 pending
        lane_red = 4'b1011;
        do_reset();
        lane_req = 4'b0100;
        step();
        lane_req = 4'b0000;
        step();
        check("basic_pending", 32'(pending), 32'h4);
        lane_red = 4'b1111;
        serve(g, n, g_next);
        check("basic_latency", 32'(n), 32'd13);
        check("basic_grant", 32'(g), 32'h4);
        check("basic_one_cycle", 32'(g_next), 32'h0);
        check("basic_active", 32'(active_lane), 32'h2);
        check("basic_pending_clr", 32'(pending), 32'h0);

        // Density priority with round-robin tie-break
        do_reset();
        density  = 8'b11_00_11_01;
        lane_req = 4'b1011;
        step();
        lane_req = 4'b0000;
        serve(g, n, g_next);
        check("dens_r1_grant", 32'(g), 32'h2);
        check("dens_r1_active", 32'(active_lane), 32'h1);
        serve(g, n, g_next);
        check("dens_r2_grant", 32'(g), 32'h8);
        check("dens_r2_active", 32'(active_lane), 32'h3);
        serve(g, n, g_next);
        check("dens_r3_grant", 32'(g), 32'h1);
        check("dens_r3_pending", 32'(pending), 32'h0);

        // Starvation guard: lane 0 wins after three skips
        do_reset();
        density  = 8'b00_11_11_00;
        lane_req = 4'b0111;
        step();
        lane_req = 4'b0110;
        serve(g, n, g_next);
        check("starve_r1", 32'(g), 32'h2);
        serve(g, n, g_next);
        check("starve_r2", 32'(g), 32'h4);
        serve(g, n, g_next);
        check("starve_r3", 32'(g), 32'h2);
        serve(g, n, g_next);
        check("starve_r4", 32'(g), 32'h1);
        lane_req = 4'b0000;

        // Conflict during clearance
        do_reset();
        density  = 8'h00;
        lane_req = 4'b0001;
        step();
        lane_req = 4'b0000;
        step(); step();
        check("conf_fault_pre", 32'(fault), 32'h0);
        lane_red = 4'b1101;
        step();
        check("conf_fault_set", 32'(fault), 32'h1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (grant != 4'b0000) seen++;
        end
        check("conf_no_grant", 32'(seen), 32'h0);
        lane_red = 4'b1111;
        serve(g, n, g_next);
        check("conf_latency", 32'(n), 32'd13);
        check("conf_grant", 32'(g), 32'h1);
        check("conf_fault_sticky", 32'(fault), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
